// File: rtl/pci_master_arbiter.sv
// pci_master_arbiter
//   Shares the single PCI initiator user interface among NREQ local requesters.
//   Picks a requester, sequences request/address/data phases, tracks remaining
//   dwords and the current address, re-issues the cycle after a retry or
//   disconnect, and reports per-requester done/error.
//   Build macro: PCI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
//   instead of round-robin (default build: round-robin).
//   RETRY_GAP must be at least 1; NREQ must be 2..8.
module pci_master_arbiter #(
    parameter int NREQ      = 4,
    parameter int LEN_W     = 8,
    parameter int MAX_RETRY = 15,
    parameter int RETRY_GAP = 2
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*32-1:0]    req_addr,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]       req_dir,
    output logic [NREQ-1:0]       req_grant,
    output logic [NREQ-1:0]       req_done,
    output logic [NREQ-1:0]       req_err,
    output logic [2:0]            cur_sel,
    output logic [31:0]           cur_addr,
    input  logic                  m_addr_n,
    input  logic                  m_data,
    input  logic                  m_data_vld,
    input  logic [39:0]           csr,
    output logic                  request,
    output logic                  requesthold,
    output logic                  complete,
    output logic                  m_ready,
    output logic [3:0]            m_cbe,
    output logic                  m_wrdn
);

    localparam int RC_W  = $clog2(MAX_RETRY + 2);
    localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DATA,
        S_GAP,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [2:0]         r_rr_ptr;
    logic [2:0]         r_sel;
    logic [29:0]        r_addr;
    logic [LEN_W-1:0]   r_rem;
    logic               r_dir;
    logic [RC_W-1:0]    r_retry_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_request;
    logic               r_m_ready;
    logic               r_m_data_q;
    logic [NREQ-1:0]    r_req_grant;
    logic [NREQ-1:0]    r_req_done;
    logic [NREQ-1:0]    r_req_err;

    // Descriptor slices padded to 8 entries so a 3-bit select indexes them cleanly
    logic [29:0]        w_addr_arr [8];
    logic [LEN_W-1:0]   w_len_arr  [8];
    logic               w_dir_arr  [8];
    logic [NREQ*2-1:0]  w_addr_lo_unused;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slice
            if (gi < NREQ) begin : g_used
                assign w_addr_arr[gi]             = req_addr[gi*32+2 +: 30];
                assign w_len_arr[gi]              = req_len[gi*LEN_W +: LEN_W];
                assign w_dir_arr[gi]              = req_dir[gi];
                assign w_addr_lo_unused[gi*2 +: 2] = req_addr[gi*32 +: 2];
            end else begin : g_pad
                assign w_addr_arr[gi] = '0;
                assign w_len_arr[gi]  = '0;
                assign w_dir_arr[gi]  = 1'b0;
            end
        end
    endgenerate

    // Byte-offset address bits and unused status bits are deliberately ignored
    logic w_unused;
    assign w_unused = ^{w_addr_lo_unused, csr[37], csr[35:0]};

    // Arbitration: rotate the request vector so the search starts at the base index
    logic [2:0]        w_base;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [2:0]        w_off;
    logic              w_found;
    logic [3:0]        w_sum;
    logic [2:0]        w_pick;

`ifdef PCI_ARB_FIXED_PRIO_EN
    assign w_base = 3'd0;
`else
    assign w_base = r_rr_ptr;
`endif

    assign w_dbl = {req_valid, req_valid};
    assign w_rot = NREQ'(w_dbl >> w_base);

    // Lowest set bit of the rotated vector is the winner's offset from the base
    always_comb begin
        w_off   = 3'd0;
        w_found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = 3'(k);
                w_found = 1'b1;
            end
        end
    end

    assign w_sum  = 4'(w_base) + 4'(w_off);
    assign w_pick = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : 3'(w_sum);

    // Data-phase bookkeeping for the current cycle
    logic [LEN_W-1:0] w_rem_dec;
    logic [29:0]      w_addr_inc;
    logic [RC_W-1:0]  w_retry_inc;
    logic             w_fall;
    logic             w_beat;

    assign w_beat      = m_data_vld && (r_rem != '0);
    assign w_rem_dec   = w_beat ? (r_rem - LEN_W'(1)) : r_rem;
    assign w_addr_inc  = w_beat ? (r_addr + 30'd1) : r_addr;
    assign w_retry_inc = r_retry_cnt + RC_W'(1);
    assign w_fall      = r_m_data_q && !m_data;

    // Main sequencer: arbitration, phase tracking, retry handling and pulse outputs
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= 3'd0;
            r_sel       <= 3'd0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_dir       <= 1'b0;
            r_retry_cnt <= '0;
            r_gap_cnt   <= '0;
            r_request   <= 1'b0;
            r_m_ready   <= 1'b0;
            r_m_data_q  <= 1'b0;
            r_req_grant <= '0;
            r_req_done  <= '0;
            r_req_err   <= '0;
        end else begin
            r_m_ready   <= 1'b1;
            r_m_data_q  <= m_data;
            r_request   <= 1'b0;
            r_req_grant <= '0;
            r_req_done  <= '0;
            r_req_err   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_sel       <= w_pick;
                        r_addr      <= w_addr_arr[w_pick];
                        r_rem       <= w_len_arr[w_pick];
                        r_dir       <= w_dir_arr[w_pick];
                        r_req_grant <= NREQ'(1) << w_pick;
`ifndef PCI_ARB_FIXED_PRIO_EN
                        r_rr_ptr    <= (w_pick == 3'(NREQ - 1)) ? 3'd0 : (w_pick + 3'd1);
`endif
                        if (w_len_arr[w_pick] == '0) begin
                            // Empty descriptor: fail it without touching the bus
                            r_state    <= S_DONE;
                            r_req_done <= NREQ'(1) << w_pick;
                            r_req_err  <= NREQ'(1) << w_pick;
                        end else begin
                            r_state   <= S_REQ;
                            r_request <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (!m_addr_n) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_rem  <= w_rem_dec;
                    r_addr <= w_addr_inc;
                    if (w_fall) begin
                        if (csr[39] || csr[38]) begin
                            r_state    <= S_DONE;
                            r_req_done <= NREQ'(1) << r_sel;
                            r_req_err  <= NREQ'(1) << r_sel;
                        end else if (w_rem_dec == '0) begin
                            r_state    <= S_DONE;
                            r_req_done <= NREQ'(1) << r_sel;
                        end else if (w_retry_inc > RC_W'(MAX_RETRY)) begin
                            r_state    <= S_DONE;
                            r_req_done <= NREQ'(1) << r_sel;
                            r_req_err  <= NREQ'(1) << r_sel;
                        end else begin
                            r_retry_cnt <= w_retry_inc;
                            r_gap_cnt   <= '0;
                            r_state     <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(RETRY_GAP - 1)) begin
                        r_state   <= S_REQ;
                        r_request <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    r_retry_cnt <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // complete looks one beat ahead so the core can end the burst on the last dword
    assign complete = ((r_state == S_REQ) || (r_state == S_DATA)) &&
                      ((r_rem <= LEN_W'(1)) || ((r_rem == LEN_W'(2)) && m_data_vld));

    assign m_cbe       = (!m_addr_n && ((r_state == S_REQ) || (r_state == S_DATA))) ?
                         {3'b011, r_dir} : 4'b0000;
    assign request     = r_request;
    assign requesthold = 1'b0;
    assign m_ready     = r_m_ready;
    assign m_wrdn      = r_dir;
    assign cur_sel     = r_sel;
    assign cur_addr    = {r_addr, 2'b00};
    assign req_grant   = r_req_grant;
    assign req_done    = r_req_done;
    assign req_err     = r_req_err;

endmodule
